// File: rtl/mcb_lfsr_tester_if.sv
// rtl/mcb_lfsr_tester_if.sv - MCB user-port command/data bundle between the tester and the controller
interface mcb_lfsr_tester_if #(
  parameter int DQ_W = 16,
  parameter int BA_W = 2,
  parameter int RA_W = 12,
  parameter int CA_W = 8
);
  logic            mcb_bb;
  logic            mcb_wr_n;
  logic [1:0]      mcb_bl;
  logic [BA_W-1:0] mcb_ba;
  logic [RA_W-1:0] mcb_ra;
  logic [CA_W-1:0] mcb_ca;
  logic            mcb_busy;
  logic            mcb_rdat_vld;
  logic            mcb_wdat_req;
  logic [DQ_W-1:0] mcb_rdat;
  logic [DQ_W-1:0] mcb_wdat;

  modport master (
    output mcb_bb, mcb_wr_n, mcb_bl, mcb_ba, mcb_ra, mcb_ca, mcb_wdat,
    input  mcb_busy, mcb_rdat_vld, mcb_wdat_req, mcb_rdat
  );

  modport slave (
    input  mcb_bb, mcb_wr_n, mcb_bl, mcb_ba, mcb_ra, mcb_ca, mcb_wdat,
    output mcb_busy, mcb_rdat_vld, mcb_wdat_req, mcb_rdat
  );
endinterface

// File: rtl/mcb_lfsr_tester.sv
// rtl/mcb_lfsr_tester.sv - per-bank LFSR write/read-back traffic generator with sticky pass status
module mcb_lfsr_tester #(
  parameter int             DQ_W      = 16,
  parameter int             BA_W      = 2,
  parameter int             RA_W      = 12,
  parameter int             CA_W      = 8,
  parameter logic [1:0]     BL_CODE   = 2'b11,
  parameter int             ROW_LIMIT = 4096,
  parameter logic [DQ_W-1:0] SEED     = 16'hACE1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  output logic [15:0] sys_cmp,
  mcb_lfsr_tester_if.master mcb
);
  localparam int BEATS = 1 << BL_CODE;

  typedef enum logic [2:0] {IDLE, WR_CMD, WR_DAT, RD_CMD, RD_DAT, NEXT} state_t;

  state_t          state, state_nx;
  logic [BA_W-1:0] bank, bank_nx;
  logic [RA_W-1:0] ra, ra_nx;
  logic [CA_W-1:0] ca, ca_nx, ca_inc;
  logic [DQ_W-1:0] lfsr, lfsr_nx, lfsr_adv;
  logic [3:0]      beat, beat_nx;
  logic [15:0]     cmp, cmp_nx;
  logic            bb, bb_nx, wr_n, wr_n_nx;
  logic            last_beat, last_row;
  logic [3:0]      nb;

  function automatic logic [DQ_W-1:0] seed_of(input logic [BA_W-1:0] b);
    return SEED ^ (DQ_W'(b) << (DQ_W - BA_W));
  endfunction

  assign lfsr_adv  = {lfsr[DQ_W-2:0], lfsr[DQ_W-1] ^ lfsr[DQ_W-3] ^ lfsr[DQ_W-4] ^ lfsr[DQ_W-6]};
  assign ca_inc    = ca + CA_W'(BEATS);
  assign last_beat = (beat == 4'(BEATS - 1));
  // The region ends on the column wrap of the last row; ra itself may wrap when ROW_LIMIT == 2**RA_W.
  assign last_row  = (ca_inc == '0) && ((int'(ra) + 1) == ROW_LIMIT);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      bank  <= '0;
      ra    <= '0;
      ca    <= '0;
      lfsr  <= seed_of('0);
      beat  <= '0;
      cmp   <= 16'h4444;
      bb    <= 1'b0;
      wr_n  <= 1'b1;
    end else begin
      state <= state_nx;
      bank  <= bank_nx;
      ra    <= ra_nx;
      ca    <= ca_nx;
      lfsr  <= lfsr_nx;
      beat  <= beat_nx;
      cmp   <= cmp_nx;
      bb    <= bb_nx;
      wr_n  <= wr_n_nx;
    end
  end

  always_comb begin
    state_nx = state;
    bank_nx  = bank;
    ra_nx    = ra;
    ca_nx    = ca;
    lfsr_nx  = lfsr;
    beat_nx  = beat;
    cmp_nx   = cmp;
    bb_nx    = 1'b0;
    wr_n_nx  = wr_n;
    nb       = 4'(bank) << 2;

    // Beats the controller produces when no burst of that direction is open count as errors.
    if (mcb.mcb_rdat_vld && state != RD_DAT) cmp_nx[nb + 4'd2] = 1'b0;
    if (mcb.mcb_wdat_req && state != WR_DAT) cmp_nx[nb + 4'd2] = 1'b0;

    case (state)
      IDLE: begin
        if (!mcb.mcb_busy) begin
          state_nx = WR_CMD;
          bank_nx  = '0;
          ra_nx    = '0;
          ca_nx    = '0;
          lfsr_nx  = seed_of('0);
        end
      end
      WR_CMD: begin
        if (!mcb.mcb_busy) begin
          bb_nx    = 1'b1;
          wr_n_nx  = 1'b0;
          beat_nx  = '0;
          state_nx = WR_DAT;
        end
      end
      WR_DAT: begin
        if (mcb.mcb_wdat_req) begin
          lfsr_nx = lfsr_adv;
          beat_nx = beat + 4'd1;
          if (last_beat) begin
            ca_nx = ca_inc;
            if (ca_inc == '0) ra_nx = ra + 1'b1;
            if (last_row) begin
              cmp_nx[nb] = 1'b1;
              lfsr_nx    = seed_of(bank);
              ra_nx      = '0;
              ca_nx      = '0;
              state_nx   = RD_CMD;
            end else begin
              state_nx = WR_CMD;
            end
          end
        end
      end
      RD_CMD: begin
        if (!mcb.mcb_busy) begin
          bb_nx    = 1'b1;
          wr_n_nx  = 1'b1;
          beat_nx  = '0;
          state_nx = RD_DAT;
        end
      end
      RD_DAT: begin
        if (mcb.mcb_rdat_vld) begin
          lfsr_nx = lfsr_adv;
          beat_nx = beat + 4'd1;
          if (mcb.mcb_rdat != lfsr) cmp_nx[nb + 4'd2] = 1'b0;
          if (last_beat) begin
            ca_nx = ca_inc;
            if (ca_inc == '0) ra_nx = ra + 1'b1;
            if (last_row) begin
              cmp_nx[nb + 4'd1] = 1'b1;
              cmp_nx[nb + 4'd3] = cmp_nx[nb + 4'd2];
              state_nx          = NEXT;
            end else begin
              state_nx = RD_CMD;
            end
          end
        end
      end
      NEXT: begin
        bank_nx  = bank + 1'b1;
        ra_nx    = '0;
        ca_nx    = '0;
        lfsr_nx  = seed_of(bank + 1'b1);
        state_nx = WR_CMD;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign mcb.mcb_bb   = bb;
  assign mcb.mcb_wr_n = wr_n;
  assign mcb.mcb_bl   = BL_CODE;
  assign mcb.mcb_ba   = bank;
  assign mcb.mcb_ra   = ra;
  assign mcb.mcb_ca   = ca;
  assign mcb.mcb_wdat = lfsr;
  assign sys_cmp      = cmp;
endmodule

// File: tb/tb_mcb_lfsr_tester.sv
// tb/tb_mcb_lfsr_tester.sv - self-checking bench for mcb_lfsr_tester with a behavioural MCB memory model
`timescale 1ns/1ps
module tb_mcb_lfsr_tester;
  localparam int DQ_W = 16, BA_W = 2, RA_W = 12, CA_W = 8;
  localparam int ROW_LIMIT     = 2;
  localparam int BEATS         = 8;
  localparam int BURSTS_ROW    = 256 / BEATS;
  localparam int CMDS_PER_BANK = 2 * ROW_LIMIT * BURSTS_ROW;
  localparam int CMDS_PER_PASS = 4 * CMDS_PER_BANK;
  localparam int WBEATS_BANK   = ROW_LIMIT * 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sys_cmp;

  always #5 clk = ~clk;

  mcb_lfsr_tester_if #(.DQ_W(DQ_W), .BA_W(BA_W), .RA_W(RA_W), .CA_W(CA_W)) mcb ();

  mcb_lfsr_tester #(
    .DQ_W(DQ_W), .BA_W(BA_W), .RA_W(RA_W), .CA_W(CA_W),
    .BL_CODE(2'b11), .ROW_LIMIT(ROW_LIMIT), .SEED(16'hACE1)
  ) dut (
    .sys_clk(clk),
    .sys_rst_n(rst_n),
    .sys_cmp(sys_cmp),
    .mcb(mcb)
  );

  typedef struct {
    bit          wr;
    int          ba;
    int          ra;
    int          ca;
    logic [15:0] cmp;
    bit          busy_ok;
    bit          single;
  } cmd_t;

  typedef struct {
    int          idx;
    bit          wr;
    int          ba;
    int          ra;
    int          ca;
    logic [15:0] cmp;
  } vec_t;

  cmd_t        cmd_q[$];
  logic [15:0] wr_q[$];
  logic [15:0] mem[int];
  vec_t        vec[13];

  int busy_mode = 1;
  bit delay_en  = 1'b0;
  bit flip_en   = 1'b0;
  bit flipped   = 1'b0;
  int stray_req = 0;
  int tests = 0;
  int fails = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {x[14:0], ^(x & 16'hB400)};
  endfunction

  function automatic logic [15:0] seed_of(input int b);
    return 16'hACE1 ^ 16'(b << 14);
  endfunction

  function automatic cmd_t exp_cmd(input int k);
    cmd_t c;
    int   i;
    i    = k % CMDS_PER_BANK;
    c.ba = (k / CMDS_PER_BANK) % 4;
    c.wr = (i < CMDS_PER_BANK / 2);
    i    = i % (CMDS_PER_BANK / 2);
    c.ra = i / BURSTS_ROW;
    c.ca = (i % BURSTS_ROW) * BEATS;
    c.cmp = '0;
    c.busy_ok = 1'b1;
    c.single  = 1'b1;
    return c;
  endfunction

  function automatic int pick_gap();
    if (!delay_en) return 0;
    return ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 20)) : 0;
  endfunction

  // Behavioural controller: accepts a command on bb, then streams BEATS beats with optional gaps.
  initial begin : ctrl
    int   left, gap, beat, cba, cra, col, key, done_stray;
    bit   cur_wr;
    cmd_t c;
    left = 0; gap = 0; beat = 0; cba = 0; cra = 0; col = 0; cur_wr = 1'b0; done_stray = 0;
    mcb.mcb_busy = 1'b1;
    mcb.mcb_rdat_vld = 1'b0;
    mcb.mcb_wdat_req = 1'b0;
    mcb.mcb_rdat = '0;
    forever begin
      @(negedge clk);
      mcb.mcb_wdat_req = 1'b0;
      mcb.mcb_rdat_vld = 1'b0;
      if (!rst_n) begin
        left = 0;
      end else if (mcb.mcb_bb) begin
        c.wr      = !mcb.mcb_wr_n;
        c.ba      = int'(mcb.mcb_ba);
        c.ra      = int'(mcb.mcb_ra);
        c.ca      = int'(mcb.mcb_ca);
        c.cmp     = sys_cmp;
        c.busy_ok = !mcb.mcb_busy;
        c.single  = (left == 0);
        cmd_q.push_back(c);
        cur_wr = c.wr; cba = c.ba; cra = c.ra; col = c.ca;
        beat = 0; left = BEATS; gap = pick_gap();
      end else if (left > 0) begin
        if (gap > 0) begin
          gap--;
        end else begin
          key = (cba << 20) | (cra << 8) | ((col + beat) % 256);
          if (cur_wr) begin
            mcb.mcb_wdat_req = 1'b1;
            wr_q.push_back(mcb.mcb_wdat);
            mem[key] = mcb.mcb_wdat;
          end else begin
            mcb.mcb_rdat_vld = 1'b1;
            mcb.mcb_rdat = mem.exists(key) ? mem[key] : 16'h0000;
            if (flip_en && !flipped && cba == 2 && beat == 3) begin
              mcb.mcb_rdat[0] = ~mcb.mcb_rdat[0];
              flipped = 1'b1;
            end
          end
          beat++;
          left--;
          gap = pick_gap();
        end
      end else if (stray_req != done_stray) begin
        mcb.mcb_rdat_vld = 1'b1;
        done_stray++;
      end
      mcb.mcb_busy = (busy_mode == 1) ? 1'b1 :
                     (busy_mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
  end

  task automatic wait_cmds(input int n, input string name);
    int cyc;
    cyc = 0;
    while (cmd_q.size() < n && cyc < 40000) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    check({name, "_reached"}, 64'(cmd_q.size() >= n), 64'd1);
  endtask

  task automatic check_cmds(input string name, input int n);
    int   bad, busy_bad, overlap;
    cmd_t e;
    bad = 0; busy_bad = 0; overlap = 0;
    for (int k = 0; k < n; k++) begin
      if (k >= cmd_q.size()) begin
        bad++;
      end else begin
        e = exp_cmd(k);
        if (cmd_q[k].wr != e.wr || cmd_q[k].ba != e.ba || cmd_q[k].ra != e.ra || cmd_q[k].ca != e.ca)
          bad++;
        if (!cmd_q[k].busy_ok) busy_bad++;
        if (!cmd_q[k].single) overlap++;
      end
    end
    check({name, "_cmd_order_errs"}, 64'(bad), 64'd0);
    check({name, "_bb_while_busy"}, 64'(busy_bad), 64'd0);
    check({name, "_overlapping_cmds"}, 64'(overlap), 64'd0);
  endtask

  task automatic check_wdata(input string name);
    int          bad, p;
    logic [15:0] x;
    bad = 0; p = 0;
    for (int b = 0; b < 4; b++) begin
      x = seed_of(b);
      for (int j = 0; j < WBEATS_BANK; j++) begin
        if (p >= wr_q.size() || wr_q[p] !== x) bad++;
        p++;
        x = lfsr_next(x);
      end
    end
    check({name, "_wdata_errs"}, 64'(bad), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bb"},   64'(mcb.mcb_bb),   64'd0);
    check({tag, "_wr_n"}, 64'(mcb.mcb_wr_n), 64'd1);
    check({tag, "_bl"},   64'(mcb.mcb_bl),   64'd3);
    check({tag, "_ba"},   64'(mcb.mcb_ba),   64'd0);
    check({tag, "_ra"},   64'(mcb.mcb_ra),   64'd0);
    check({tag, "_ca"},   64'(mcb.mcb_ca),   64'd0);
    check({tag, "_wdat"}, 64'(mcb.mcb_wdat), 64'hACE1);
    check({tag, "_cmp"},  64'(sys_cmp),      64'h4444);
  endtask

  initial begin : main
    int cyc;
    vec[0]  = '{0,   1'b1, 0, 0, 0,   16'h4444};
    vec[1]  = '{1,   1'b1, 0, 0, 8,   16'h4444};
    vec[2]  = '{31,  1'b1, 0, 0, 248, 16'h4444};
    vec[3]  = '{32,  1'b1, 0, 1, 0,   16'h4444};
    vec[4]  = '{63,  1'b1, 0, 1, 248, 16'h4444};
    vec[5]  = '{64,  1'b0, 0, 0, 0,   16'h4445};
    vec[6]  = '{127, 1'b0, 0, 1, 248, 16'h4445};
    vec[7]  = '{128, 1'b1, 1, 0, 0,   16'h444F};
    vec[8]  = '{256, 1'b1, 2, 0, 0,   16'h44FF};
    vec[9]  = '{320, 1'b0, 2, 0, 0,   16'h45FF};
    vec[10] = '{384, 1'b1, 3, 0, 0,   16'h4FFF};
    vec[11] = '{448, 1'b0, 3, 0, 0,   16'h5FFF};
    vec[12] = '{512, 1'b1, 0, 0, 0,   16'hFFFF};

    rst_n = 1'b0;
    busy_mode = 1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    check("busy_hold_no_bb", 64'(cmd_q.size()), 64'd0);
    check("busy_hold_cmp", 64'(sys_cmp), 64'h4444);

    busy_mode = 0;
    wait_cmds(CMDS_PER_PASS + 1, "pass1");
    foreach (vec[i]) begin
      if (vec[i].idx < cmd_q.size()) begin
        check($sformatf("vec%0d_wr", vec[i].idx),  64'(cmd_q[vec[i].idx].wr),  64'(vec[i].wr));
        check($sformatf("vec%0d_ba", vec[i].idx),  64'(cmd_q[vec[i].idx].ba),  64'(vec[i].ba));
        check($sformatf("vec%0d_ra", vec[i].idx),  64'(cmd_q[vec[i].idx].ra),  64'(vec[i].ra));
        check($sformatf("vec%0d_ca", vec[i].idx),  64'(cmd_q[vec[i].idx].ca),  64'(vec[i].ca));
        check($sformatf("vec%0d_cmp", vec[i].idx), 64'(cmd_q[vec[i].idx].cmp), 64'(vec[i].cmp));
      end else begin
        check($sformatf("vec%0d_present", vec[i].idx), 64'(cmd_q.size()), 64'(vec[i].idx + 1));
      end
    end
    check("first_wbeat", 64'(wr_q.size() > 0 ? wr_q[0] : 16'h0000), 64'hACE1);
    check_cmds("pass1", CMDS_PER_PASS + 1);
    check_wdata("pass1");

    flip_en = 1'b1;
    wait_cmds(CMDS_PER_PASS + 2 * CMDS_PER_BANK + CMDS_PER_BANK / 2 + 1, "pass2_b2_rd");
    cyc = 0;
    while (!flipped && cyc < 2000) begin
      @(posedge clk);
      cyc++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("flip_injected", 64'(flipped), 64'd1);
    check("mismatch_clears_b2_nm", 64'(sys_cmp[10]), 64'd0);
    check("b2_passed_held_until_done", 64'(sys_cmp[11]), 64'd1);
    wait_cmds(2 * CMDS_PER_PASS + 1, "pass2");
    if (cmd_q.size() > 2 * CMDS_PER_PASS)
      check("pass2_cmp", 64'(cmd_q[2 * CMDS_PER_PASS].cmp), 64'hF3FF);
    check("pass2_b2_nibble", 64'(sys_cmp[11:8]), 64'h3);

    flip_en = 1'b0;
    wait_cmds(2 * CMDS_PER_PASS + CMDS_PER_BANK + 1, "pass3_b1_wr");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midburst_rst");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    cmd_q.delete();
    wr_q.delete();
    mem.delete();
    delay_en = 1'b1;
    busy_mode = 2;
    rst_n = 1'b1;

    wait_cmds(CMDS_PER_PASS + 1, "rand");
    if (cmd_q.size() > 0) begin
      check("restart_wr", 64'(cmd_q[0].wr), 64'd1);
      check("restart_ba", 64'(cmd_q[0].ba), 64'd0);
    end
    check_cmds("rand", CMDS_PER_PASS + 1);
    check_wdata("rand");
    if (cmd_q.size() > CMDS_PER_PASS)
      check("rand_cmp", 64'(cmd_q[CMDS_PER_PASS].cmp), 64'hFFFF);

    rst_n = 1'b0;
    busy_mode = 1;
    delay_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmd_q.delete();
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    stray_req++;
    repeat (4) @(posedge clk);
    #1;
    check("stray_vld_clears_nm", 64'(sys_cmp), 64'h4440);
    check("stray_no_cmd", 64'(cmd_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
